// File: rtl/ercm8_6_approx_mult.sv
// 8x8 unsigned approximate multiplier: columns 0..6 can each be switched to an
// OR-reduced, carry-free mode via mask; the product is registered once.
module ercm8_6_approx_mult (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  dat_in_a,
   input  logic [7:0]  dat_in_b,
   input  logic [6:0]  mask,
   output logic [15:0] dat_o
);

   logic [7:0]  w_pp [8];
   logic [3:0]  w_cnt [15];
   logic        w_or [15];
   logic [3:0]  w_wt [15];
   logic [14:0] w_exact;
   logic [15:0] w_row [4];
   logic [15:0] w_s0, w_c0, w_s1, w_c1, w_r;
   logic [15:0] r_dat;

   // 3:2 carry-save compressor over three 16-bit rows; returns {sum, carry<<1}.
   function automatic logic [31:0] csa3(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
      logic [15:0] s;
      logic [15:0] cy;
      s  = x ^ y ^ z;
      cy = ((x & y) | (x & z) | (y & z)) << 1;
      return {s, cy};
   endfunction

   function automatic logic [15:0] cpa16(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] s;
      logic        c;
      c = 1'b0;
      for (int k = 0; k < 16; k++) begin
         s[k] = x[k] ^ y[k] ^ c;
         c    = (x[k] & y[k]) | (x[k] & c) | (y[k] & c);
      end
      return s;
   endfunction

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            w_pp[i][j] = dat_in_a[i] & dat_in_b[j];
         end
      end
   end

   // Per-column population count and OR reduction of the partial products.
   always_comb begin
      for (int c = 0; c < 15; c++) begin
         w_cnt[c] = 4'd0;
         w_or[c]  = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            w_cnt[i+j] = w_cnt[i+j] + {3'b000, w_pp[i][j]};
            w_or[i+j]  = w_or[i+j] | w_pp[i][j];
         end
      end
   end

   // Upper columns are always exact; an OR-reduced column weighs at most 1,
   // so it can never launch a carry of its own.
   assign w_exact = {8'hFF, mask};

   always_comb begin
      for (int c = 0; c < 15; c++) begin
         w_wt[c] = w_exact[c] ? w_cnt[c] : {3'b000, w_or[c]};
      end
   end

   // Bit k of column c's weight lands in row k at bit position c+k.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_row[k] = 16'd0;
         for (int c = 0; c < 15; c++) begin
            w_row[k] = w_row[k] | (16'(w_wt[c][k]) << (c + k));
         end
      end
   end

   assign {w_s0, w_c0} = csa3(w_row[0], w_row[1], w_row[2]);
   assign {w_s1, w_c1} = csa3(w_s0, w_c0, w_row[3]);
   assign w_r          = cpa16(w_s1, w_c1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dat <= 16'd0;
      end else begin
         r_dat <= w_r;
      end
   end

   assign dat_o = r_dat;

endmodule

// File: tb/tb_ercm8_6_approx_mult.sv
// Scoreboard bench for ercm8_6_approx_mult: inputs driven on the falling edge,
// expected results queued and compared one cycle later.
module tb_ercm8_6_approx_mult;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  dat_in_a = 8'd0;
   logic [7:0]  dat_in_b = 8'd0;
   logic [6:0]  mask = 7'd0;
   logic [15:0] dat_o;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [6:0]  m;
      logic [15:0] exp;
   } txn_t;

   txn_t sb[$];

   always #5 clk = ~clk;

   ercm8_6_approx_mult dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .dat_in_a (dat_in_a),
      .dat_in_b (dat_in_b),
      .mask     (mask),
      .dat_o    (dat_o)
   );

   // Exact product minus the value lost in each approximated column:
   // a column holding n ones contributes 1 instead of n.
   function automatic logic [15:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [6:0] m);
      int r;
      int n;
      r = int'(a) * int'(b);
      for (int c = 0; c < 7; c++) begin
         if (!m[c]) begin
            n = 0;
            for (int i = 0; i <= c; i++) n += int'(a[i] & b[c-i]);
            if (n > 1) r -= (n - 1) << c;
         end
      end
      return r[15:0];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      dat_in_a = 8'hFF;
      dat_in_b = 8'hFF;
      mask = 7'd0;
      #1;
      n_total++;
      if (dat_o !== 16'd0) $display("FAIL reset_initial got %0d want 0", dat_o);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         n_total++;
         if (dat_o !== 16'd0) $display("FAIL reset_hold cycle %0d got %0d want 0", k, dat_o);
         else n_pass++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{8'hFF, 8'hFF, 7'd0, 16'd64383});
   endtask

   task automatic test_directed();
      txn_t tbl[9];
      txn_t t;
      tbl[0] = '{8'd255, 8'd255, 7'h7F, 16'd65025};
      tbl[1] = '{8'd3,   8'd3,   7'h7F, 16'd9};
      tbl[2] = '{8'd3,   8'd3,   7'h00, 16'd7};
      tbl[3] = '{8'd255, 8'd255, 7'h00, 16'd64383};
      tbl[4] = '{8'd3,   8'd3,   7'h02, 16'd9};
      tbl[5] = '{8'd3,   8'd3,   7'h01, 16'd7};
      tbl[6] = '{8'd1,   8'd200, 7'h00, 16'd200};
      tbl[7] = '{8'd0,   8'd173, 7'h00, 16'd0};
      tbl[8] = '{8'd128, 8'd128, 7'h00, 16'd16384};
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            t = sb.pop_front();
            n_total++;
            if (dat_o !== t.exp)
               $display("FAIL directed a=%0d b=%0d mask=%b got %0d want %0d",
                        t.a, t.b, t.m, dat_o, t.exp);
            else n_pass++;
         end
         dat_in_a = tbl[k].a;
         dat_in_b = tbl[k].b;
         mask     = tbl[k].m;
         sb.push_back(tbl[k]);
      end
   endtask

   task automatic test_back_to_back_random(input int n);
      txn_t t;
      logic [7:0] a, b;
      logic [6:0] m;
      int prod;
      for (int k = 0; k <= n; k++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            t = sb.pop_front();
            prod = int'(t.a) * int'(t.b);
            n_total++;
            if (dat_o !== t.exp)
               $display("FAIL random a=%0d b=%0d mask=%b got %0d want %0d",
                        t.a, t.b, t.m, dat_o, t.exp);
            else n_pass++;
            n_total++;
            if (int'(dat_o) > prod)
               $display("FAIL bound a=%0d b=%0d mask=%b got %0d exceeds %0d",
                        t.a, t.b, t.m, dat_o, prod);
            else n_pass++;
            if (t.m == 7'h7F) begin
               n_total++;
               if (int'(dat_o) != prod)
                  $display("FAIL exact_rand a=%0d b=%0d got %0d want %0d", t.a, t.b, dat_o, prod);
               else n_pass++;
            end
         end
         if (k < n) begin
            a = 8'($urandom);
            b = 8'($urandom);
            m = ($urandom_range(3) == 0) ? 7'h7F : 7'($urandom);
            dat_in_a = a;
            dat_in_b = b;
            mask     = m;
            sb.push_back('{a, b, m, ref_model(a, b, m)});
         end
      end
   endtask

   task automatic test_reset_midstream();
      txn_t t;
      dat_in_a = 8'd200;
      dat_in_b = 8'd211;
      mask     = 7'h7F;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (dat_o !== 16'd0) $display("FAIL async_reset got %0d want 0", dat_o);
      else n_pass++;
      sb.delete();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_total++;
         if (dat_o !== 16'd0) $display("FAIL reset_mid_hold cycle %0d got %0d want 0", k, dat_o);
         else n_pass++;
      end
      dat_in_a = 8'd3;
      dat_in_b = 8'd3;
      mask     = 7'h00;
      rst_n    = 1'b1;
      sb.push_back('{8'd3, 8'd3, 7'h00, 16'd7});
      @(negedge clk);
      t = sb.pop_front();
      n_total++;
      if (dat_o !== t.exp) $display("FAIL post_reset got %0d want %0d", dat_o, t.exp);
      else n_pass++;
   endtask

   task automatic test_flush();
      txn_t t;
      while (sb.size() > 0) begin
         @(negedge clk);
         t = sb.pop_front();
         n_total++;
         if (dat_o !== t.exp)
            $display("FAIL flush a=%0d b=%0d mask=%b got %0d want %0d",
                     t.a, t.b, t.m, dat_o, t.exp);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back_random(10000);
      test_reset_midstream();
      test_back_to_back_random(50);
      test_flush();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
